// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic datapath.
package arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle between controller and serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);

  logic             start;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow;

  modport master (output start, r1, r2, bi, input busy, done, result, borrow);
  modport slave  (input start, r1, r2, bi, output busy, done, result, borrow);

endinterface

// File: rtl/serial_subtractor_subbit.sv
// Combinational 1-bit full subtractor cell: diff = a - b - bi, with borrow out.
module subbit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = a ^ b ^ bi;
  assign bo   = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: r1 - r2 - bi computed LSB-first over WIDTH cycles with one shared subbit cell.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             reset_n,
  serial_subtractor_if.slave bus
);

  import arith_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             brw;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] d_next;

  subbit u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bi   (brw),
    .diff (cell_d),
    .bo   (cell_bo)
  );

  // New difference bit enters at the MSB so the word is aligned after WIDTH shifts.
  assign d_next = {cell_d, {(WIDTH-1){1'b0}}} | (d_sr >> 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      brw        <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state    <= S_SHIFT;
            a_sr     <= bus.r1;
            b_sr     <= bus.r2;
            brw      <= bus.bi;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end else begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_next;
          brw  <= cell_bo;
          if (cnt == LAST) begin
            bus.result <= d_next;
            bus.borrow <= cell_bo;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: stimulus pushes expected {borrow,result} from an arithmetic model; a monitor pops on done.
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;
  logic [W:0] exp_q[$];
  logic [W:0] last_exp;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction viewed as a (W+1)-bit two's-complement word.
  function automatic logic [W:0] model(input int a, input int b, input int c);
    int diff;
    diff = a - b - c;
    return diff[W:0];
  endfunction

  task automatic check_output(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      check_output("busy_with_done", int'(bus.busy), 0);
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", int'(bus.done), 0);
      end else begin
        check_output("result_borrow", int'({bus.borrow, bus.result}), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic apply_stimulus(input int a, input int b, input int c);
    @(negedge clk);
    bus.r1    = W'(a);
    bus.r2    = W'(b);
    bus.bi    = c[0];
    bus.start = 1'b1;
    last_exp  = model(a, b, c);
    exp_q.push_back(last_exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_for_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
    end
  endtask

  task automatic run_op(input int a, input int b, input int c);
    int bc;
    bit seen;
    apply_stimulus(a, b, c);
    wait_for_done(bc, seen);
    check_output("done_seen", int'(seen), 1);
    check_output("busy_cycles", bc, W);
  endtask

  initial begin
    int bc;
    int gap;
    bit seen;
    logic [W:0] hold_val;
    int order[512];

    n_vec     = 0;
    n_bad     = 0;
    bus.start = 1'b0;
    bus.r1    = '0;
    bus.r2    = '0;
    bus.bi    = 1'b0;
    reset_n   = 1'b1;
    #3 reset_n = 1'b0;
    #1 check_output("reset_outputs", int'({bus.busy, bus.done, bus.borrow, bus.result}), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(9, 3, 0);
    run_op(3, 9, 0);
    run_op(0, 0, 1);

    // Start held high through the DONE cycle launches the next operation straight away.
    @(negedge clk);
    bus.r1    = 4'd15;
    bus.r2    = 4'd15;
    bus.bi    = 1'b0;
    bus.start = 1'b1;
    last_exp  = model(15, 15, 0);
    exp_q.push_back(last_exp);
    wait_for_done(bc, seen);
    check_output("b2b_first_done", int'(seen), 1);
    bus.r1   = 4'd6;
    bus.r2   = 4'd11;
    bus.bi   = 1'b1;
    last_exp = model(6, 11, 1);
    exp_q.push_back(last_exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
    gap = 0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      gap++;
      if (bus.done) break;
    end
    check_output("b2b_done_gap", gap, W + 1);

    hold_val = last_exp;
    apply_stimulus(12, 5, 0);
    @(negedge clk);
    check_output("result_hold", int'({bus.borrow, bus.result}), int'(hold_val));
    bus.r1    = 4'd1;
    bus.r2    = 4'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_for_done(bc, seen);
    check_output("ignored_start_done", int'(seen), 1);
    check_output("busy_after_done", int'(bus.busy), 0);

    apply_stimulus(9, 4, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_output("abort_outputs", int'({bus.busy, bus.done, bus.borrow, bus.result}), 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * W) @(negedge clk);
    run_op(8, 1, 0);

    // Every r1/r2/bi combination once, in shuffled order.
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j;
      int t;
      j        = int'($urandom_range(i, 0));
      t        = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      run_op(order[i] & 15, (order[i] >> 4) & 15, (order[i] >> 8) & 1);
    end

    repeat (3) @(negedge clk);
    check_output("pending_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
